// File: rtl/mem_access_router.sv
// Routes one load/store/fetch at a time to the cached memory port or the uncached IO port,
// using PMA attributes, with fetch execute checking and an IO-path bus-timeout watchdog.
module mem_access_router #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int XLEN           = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [3:0]      req_wstrb_i,
  input  logic            req_we_i,
  input  logic            req_fetch_i,
  output logic [XLEN-1:0] pma_addr_o,
  input  logic            pma_uncached_i,
  input  logic            pma_memregion_i,
  input  logic            pma_grand_i,
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic            io_valid_o,
  input  logic            io_ready_i,
  output logic [XLEN-1:0] tgt_addr_o,
  output logic [XLEN-1:0] tgt_wdata_o,
  output logic [3:0]      tgt_wstrb_o,
  output logic            tgt_we_o,
  input  logic            mem_rsp_valid_i,
  input  logic [XLEN-1:0] mem_rsp_data_i,
  input  logic            io_rsp_valid_i,
  input  logic [XLEN-1:0] io_rsp_data_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            rsp_err_o,
  output logic [1:0]      dbg_state_o
);

  // Handshake: a transfer happens on a rising clk edge where valid and ready are both high;
  // valid, once raised, is held with its payload stable until that edge.

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [3:0]      wstrb_q;
  logic            we_q;
  logic            route_io_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rsp_data_q;
  logic            rsp_err_q;

  logic            accept;
  logic            route_io_in;
  logic            fault_in;
  logic            timeout;
  logic            tgt_ready;
  logic            tgt_rsp;
  logic [XLEN-1:0] tgt_rsp_data;
  logic            rsp_load;
  logic [XLEN-1:0] rsp_data_d;
  logic            rsp_err_d;

  always_comb begin
    accept       = (state_q == IDLE) && req_valid_i;
    route_io_in  = !(pma_memregion_i && !pma_uncached_i);
    fault_in     = req_fetch_i && !pma_grand_i;
    timeout      = route_io_q && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    tgt_ready    = route_io_q ? io_ready_i : mem_ready_i;
    tgt_rsp      = route_io_q ? io_rsp_valid_i : mem_rsp_valid_i;
    tgt_rsp_data = route_io_q ? io_rsp_data_i : mem_rsp_data_i;
  end

  // Next state and the value to register into the response; a response in the
  // timeout cycle takes priority over the timeout itself.
  always_comb begin
    state_d    = state_q;
    rsp_load   = 1'b0;
    rsp_data_d = '0;
    rsp_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (fault_in) begin
            state_d   = RESP;
            rsp_load  = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (timeout) begin
          state_d   = RESP;
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
        end else if (tgt_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (tgt_rsp) begin
          state_d    = RESP;
          rsp_load   = 1'b1;
          rsp_data_d = we_q ? '0 : tgt_rsp_data;
        end else if (timeout) begin
          state_d   = RESP;
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      we_q       <= 1'b0;
      route_io_q <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= req_addr_i;
        wdata_q    <= req_wdata_i;
        wstrb_q    <= req_wstrb_i;
        we_q       <= req_we_i;
        route_io_q <= route_io_in;
        cnt_q      <= '0;
      end else if (state_q == ISSUE || state_q == WAIT) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (rsp_load) begin
        rsp_data_q <= rsp_data_d;
        rsp_err_q  <= rsp_err_d;
      end else if (state_q == RESP) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    pma_addr_o  = req_addr_i;
    mem_valid_o = (state_q == ISSUE) && !route_io_q;
    io_valid_o  = (state_q == ISSUE) && route_io_q;
    tgt_addr_o  = addr_q;
    tgt_wdata_o = wdata_q;
    tgt_wstrb_o = wstrb_q;
    tgt_we_o    = we_q;
    rsp_valid_o = (state_q == RESP);
    rsp_data_o  = rsp_data_q;
    rsp_err_o   = rsp_err_q;
    dbg_state_o = state_q;
  end

endmodule
